// File: rtl/tb_cycle_mon.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_cycle_mon                                                      |
// | Desc     : Watches a DUT cycle counter for continuity, forward progress and |
// |            run-time budget; latches a sticky pass/fail verdict.             |
// |            Optional TB_CYCLE_MON_DPI_EN adds a tb_pkg::tb_error report.     |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_cycle_mon #(
    parameter int unsigned WATCHDOG_CYCLES = 1000,
    parameter int unsigned MAX_CYCLES      = 100000
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [31:0] tb_cycle_i,
    input  logic        activity_i,
    input  logic        done_i,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [31:0] fail_cycle_o,
    output logic        finish_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [1:0] c_CODE_DISC = 2'd1;
    localparam logic [1:0] c_CODE_WDOG = 2'd2;
    localparam logic [1:0] c_CODE_OVR  = 2'd3;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_ref, w_ref_nxt;
    logic [31:0] r_wdog, w_wdog_nxt;
    logic [31:0] r_elapsed, w_elapsed_nxt;
    logic        r_err, w_err_nxt;
    logic [1:0]  r_code, w_code_nxt;
    logic [31:0] r_fcyc, w_fcyc_nxt;
    logic        r_fin, w_fin_nxt;

    logic [31:0] w_wdog_inc;
    logic [31:0] w_elapsed_inc;
    logic        w_disc;
    logic        w_timeout;
    logic        w_overrun;

    // Saturating increments so long runs can never alias back to small counts.
    assign w_wdog_inc    = (r_wdog == 32'hFFFF_FFFF)    ? r_wdog    : r_wdog + 32'd1;
    assign w_elapsed_inc = (r_elapsed == 32'hFFFF_FFFF) ? r_elapsed : r_elapsed + 32'd1;

    assign w_disc    = (tb_cycle_i != (r_ref + 32'd1));
    assign w_timeout = (WATCHDOG_CYCLES != 0) && !activity_i && (w_wdog_inc >= WATCHDOG_CYCLES);
    assign w_overrun = (MAX_CYCLES != 0) && (w_elapsed_inc >= MAX_CYCLES);

    always_comb begin
        w_state_nxt   = r_state;
        w_ref_nxt     = r_ref;
        w_wdog_nxt    = r_wdog;
        w_elapsed_nxt = r_elapsed;
        w_err_nxt     = r_err;
        w_code_nxt    = r_code;
        w_fcyc_nxt    = r_fcyc;
        w_fin_nxt     = r_fin;
        case (r_state)
            ST_IDLE: begin
                w_ref_nxt     = tb_cycle_i;
                w_wdog_nxt    = 32'd0;
                w_elapsed_nxt = 32'd0;
                w_state_nxt   = ST_RUN;
            end
            ST_RUN: begin
                w_ref_nxt     = tb_cycle_i;
                w_wdog_nxt    = activity_i ? 32'd0 : w_wdog_inc;
                w_elapsed_nxt = w_elapsed_inc;
                if (w_disc || w_timeout || w_overrun) begin
                    // Only the highest-priority error is reported.
                    w_state_nxt = ST_FAIL;
                    w_err_nxt   = 1'b1;
                    w_fcyc_nxt  = tb_cycle_i;
                    if (w_disc)
                        w_code_nxt = c_CODE_DISC;
                    else if (w_timeout)
                        w_code_nxt = c_CODE_WDOG;
                    else
                        w_code_nxt = c_CODE_OVR;
                end else if (done_i) begin
                    w_state_nxt = ST_DONE;
                    w_fin_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state   <= ST_IDLE;
            r_ref     <= 32'd0;
            r_wdog    <= 32'd0;
            r_elapsed <= 32'd0;
            r_err     <= 1'b0;
            r_code    <= 2'd0;
            r_fcyc    <= 32'd0;
            r_fin     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ref     <= w_ref_nxt;
            r_wdog    <= w_wdog_nxt;
            r_elapsed <= w_elapsed_nxt;
            r_err     <= w_err_nxt;
            r_code    <= w_code_nxt;
            r_fcyc    <= w_fcyc_nxt;
            r_fin     <= w_fin_nxt;
        end
    end

`ifdef TB_CYCLE_MON_DPI_EN
    always_ff @(posedge clk) begin
        if (!arst && (r_state == ST_RUN) && (w_state_nxt == ST_FAIL))
            tb_pkg::tb_error(`__FILE__, `__LINE__,
                $sformatf("tb_cycle_mon: error code %0d at cycle 0x%08h", w_code_nxt, tb_cycle_i));
    end
`endif

    assign err_o        = r_err;
    assign err_code_o   = r_code;
    assign fail_cycle_o = r_fcyc;
    assign finish_o     = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_tb_cycle_mon.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_tb_cycle_mon                                                   |
// | Desc     : Directed bench for tb_cycle_mon across three parameter sets.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_tb_cycle_mon;

    logic        clk;
    logic        arst;
    logic [31:0] tb_cycle;
    logic        activity;
    logic        done;

    logic        a_err, b_err, c_err;
    logic [1:0]  a_code, b_code, c_code;
    logic [31:0] a_fcyc, b_fcyc, c_fcyc;
    logic        a_fin, b_fin, c_fin;

    int n_total;
    int n_pass;

    tb_cycle_mon dut_a (
        .clk(clk), .arst(arst), .tb_cycle_i(tb_cycle), .activity_i(activity), .done_i(done),
        .err_o(a_err), .err_code_o(a_code), .fail_cycle_o(a_fcyc), .finish_o(a_fin)
    );

    tb_cycle_mon #(.WATCHDOG_CYCLES(4), .MAX_CYCLES(0)) dut_b (
        .clk(clk), .arst(arst), .tb_cycle_i(tb_cycle), .activity_i(activity), .done_i(done),
        .err_o(b_err), .err_code_o(b_code), .fail_cycle_o(b_fcyc), .finish_o(b_fin)
    );

    tb_cycle_mon #(.WATCHDOG_CYCLES(4), .MAX_CYCLES(4)) dut_c (
        .clk(clk), .arst(arst), .tb_cycle_i(tb_cycle), .activity_i(activity), .done_i(done),
        .err_o(c_err), .err_code_o(c_code), .fail_cycle_o(c_fcyc), .finish_o(c_fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: inputs applied at the falling edge, outputs settled 1 ns after the rising edge.
    task automatic step(input logic [31:0] cyc, input logic act, input logic dn, input logic rst);
        @(negedge clk);
        tb_cycle = cyc;
        activity = act;
        done     = dn;
        arst     = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        arst     = 1'b1;
        tb_cycle = 32'd0;
        activity = 1'b0;
        done     = 1'b0;

        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_err",  {31'd0, a_err},  32'd0);
        chk("rst_code", {30'd0, a_code}, 32'd0);
        chk("rst_fcyc", a_fcyc,          32'd0);
        chk("rst_fin",  {31'd0, a_fin},  32'd0);

        // Contiguous 100..199, activity every fifth cycle, done at 150.
        step(32'd100, 1'b0, 1'b0, 1'b0);
        chk("idle_fin", {31'd0, a_fin}, 32'd0);
        for (int c = 101; c < 200; c++) begin
            step(32'(c), (c % 5) == 0, c == 150, 1'b0);
            chk("run_err", {31'd0, a_err}, 32'd0);
            chk("run_fin", {31'd0, a_fin}, {31'd0, c >= 150});
        end

        // Wrap of the counter through zero.
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step(32'hFFFF_FFFE + 32'(c), 1'b1, 1'b0, 1'b0);
            chk("wrap_err_a", {31'd0, a_err}, 32'd0);
            chk("wrap_err_b", {31'd0, b_err}, 32'd0);
        end

        // Skip 41 -> 43.
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'd38, 1'b1, 1'b0, 1'b0);
        step(32'd39, 1'b1, 1'b0, 1'b0);
        step(32'd40, 1'b1, 1'b0, 1'b0);
        step(32'd41, 1'b1, 1'b0, 1'b0);
        chk("skip_pre_err", {31'd0, a_err}, 32'd0);
        step(32'd43, 1'b1, 1'b0, 1'b0);
        chk("skip_err",  {31'd0, a_err},  32'd1);
        chk("skip_code", {30'd0, a_code}, 32'd1);
        chk("skip_fcyc", a_fcyc,          32'd43);
        step(32'd99, 1'b1, 1'b1, 1'b0);
        chk("skip_hold_fcyc", a_fcyc,         32'd43);
        chk("skip_hold_fin",  {31'd0, a_fin}, 32'd0);
        chk("skip_hold_code", {30'd0, a_code}, 32'd1);

        // Watchdog: four idle RUN cycles time out.
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'd10, 1'b1, 1'b0, 1'b0);
        step(32'd11, 1'b0, 1'b0, 1'b0);
        step(32'd12, 1'b0, 1'b0, 1'b0);
        step(32'd13, 1'b0, 1'b0, 1'b0);
        chk("wd3_err", {31'd0, b_err}, 32'd0);
        step(32'd14, 1'b0, 1'b0, 1'b0);
        chk("wd4_err",  {31'd0, b_err},  32'd1);
        chk("wd4_code", {30'd0, b_code}, 32'd2);
        chk("wd4_fcyc", b_fcyc,          32'd14);

        // Activity on the third cycle restarts the count.
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'd10, 1'b0, 1'b0, 1'b0);
        step(32'd11, 1'b0, 1'b0, 1'b0);
        step(32'd12, 1'b0, 1'b0, 1'b0);
        step(32'd13, 1'b1, 1'b0, 1'b0);
        step(32'd14, 1'b0, 1'b0, 1'b0);
        step(32'd15, 1'b0, 1'b0, 1'b0);
        step(32'd16, 1'b0, 1'b0, 1'b0);
        chk("wdr_err", {31'd0, b_err}, 32'd0);
        step(32'd17, 1'b0, 1'b0, 1'b0);
        chk("wdr_code", {30'd0, b_code}, 32'd2);
        chk("wdr_fcyc", b_fcyc,          32'd17);

        // Discontinuity outranks a coincident watchdog timeout.
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'd10, 1'b0, 1'b0, 1'b0);
        step(32'd11, 1'b0, 1'b0, 1'b0);
        step(32'd12, 1'b0, 1'b0, 1'b0);
        step(32'd13, 1'b0, 1'b0, 1'b0);
        step(32'd15, 1'b0, 1'b0, 1'b0);
        chk("pri_disc_code", {30'd0, b_code}, 32'd1);

        // Overrun alone with steady activity.
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'd20, 1'b1, 1'b0, 1'b0);
        step(32'd21, 1'b1, 1'b0, 1'b0);
        step(32'd22, 1'b1, 1'b0, 1'b0);
        step(32'd23, 1'b1, 1'b0, 1'b0);
        chk("ovr3_err", {31'd0, c_err}, 32'd0);
        step(32'd24, 1'b1, 1'b0, 1'b0);
        chk("ovr_code", {30'd0, c_code}, 32'd3);
        chk("ovr_fcyc", c_fcyc,          32'd24);

        // Watchdog and overrun together with done: watchdog wins.
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'd10, 1'b0, 1'b0, 1'b0);
        step(32'd11, 1'b0, 1'b0, 1'b0);
        step(32'd12, 1'b0, 1'b0, 1'b0);
        step(32'd13, 1'b0, 1'b0, 1'b0);
        step(32'd14, 1'b0, 1'b1, 1'b0);
        chk("pri_err",  {31'd0, c_err},  32'd1);
        chk("pri_code", {30'd0, c_code}, 32'd2);
        chk("pri_fin",  {31'd0, c_fin},  32'd0);
        chk("pri_fcyc", c_fcyc,          32'd14);

        // One-cycle reset out of FAIL, then a clean run.
        step(32'd0, 1'b0, 1'b0, 1'b1);
        chk("rf_err",  {31'd0, c_err},  32'd0);
        chk("rf_code", {30'd0, c_code}, 32'd0);
        chk("rf_fcyc", c_fcyc,          32'd0);
        chk("rf_fin",  {31'd0, c_fin},  32'd0);
        step(32'd500, 1'b0, 1'b0, 1'b0);
        step(32'd501, 1'b1, 1'b0, 1'b0);
        step(32'd502, 1'b1, 1'b0, 1'b0);
        chk("rf_run_fin", {31'd0, c_fin}, 32'd0);
        step(32'd503, 1'b1, 1'b1, 1'b0);
        chk("rf_done_fin", {31'd0, c_fin}, 32'd1);
        chk("rf_done_err", {31'd0, c_err}, 32'd0);
        step(32'd777, 1'b0, 1'b0, 1'b0);
        chk("rf_done_hold", {31'd0, c_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tb_cycle_mon.md
TB_CYCLE_MON -- requirements
Module: tb_cycle_mon

Interface
REQ-001 SHALL have parameter WATCHDOG_CYCLES, default 1000: consecutive cycles without activity_i before timeout; 0 disables the watchdog.
REQ-002 SHALL have parameter MAX_CYCLES, default 100000: RUN-state cycle budget before overrun; 0 disables the overrun check.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port arst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port tb_cycle_i  input  32  DUT boilerplate cycle counter (tb_cycle_o of the DUT).
REQ-006 SHALL have port activity_i  input  1  DUT forward-progress strobe.
REQ-007 SHALL have port done_i  input  1  DUT test-complete strobe.
REQ-008 SHALL have port err_o  output  1  sticky error flag.
REQ-009 SHALL have port err_code_o  output  2  0 none, 1 cycle discontinuity, 2 watchdog timeout, 3 cycle budget overrun.
REQ-010 SHALL have port fail_cycle_o  output  32  tb_cycle_i value sampled in the cycle the error was detected.
REQ-011 SHALL have port finish_o  output  1  sticky pass indication.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE, FAIL; DONE and FAIL are absorbing until reset.
REQ-013 IDLE: first cycle with arst low SHALL capture tb_cycle_i as reference, clear both counters, go to RUN; no checks apply in this cycle.
REQ-014 RUN: each cycle SHALL require tb_cycle_i == reference + 1 modulo 2^32 (0xFFFFFFFF -> 0x00000000 is legal), then update reference to tb_cycle_i.
REQ-015 Watchdog counter SHALL clear on any RUN cycle with activity_i high, else increment; timeout when WATCHDOG_CYCLES consecutive RUN cycles have activity_i low.
REQ-016 Elapsed counter SHALL increment every RUN cycle; overrun when it reaches MAX_CYCLES.
REQ-017 Any detected error SHALL move RUN to FAIL; err_o, err_code_o, fail_cycle_o become valid on the following rising edge (1-cycle latency).
REQ-018 Simultaneous errors SHALL be prioritised discontinuity > watchdog > overrun; only the winner is reported.
REQ-019 done_i high in RUN with no error in that cycle SHALL move to DONE and set finish_o next edge; done_i coincident with an error SHALL be ignored (FAIL wins).
REQ-020 activity_i and done_i SHALL be ignored in IDLE, DONE and FAIL; tb_cycle_i SHALL not be checked in DONE or FAIL.
REQ-021 err_o and finish_o SHALL never be high simultaneously.
REQ-022 Counters SHALL saturate and never wrap.

Reset
REQ-023 arst high at a rising edge SHALL force state IDLE, err_o 0, err_code_o 0, fail_cycle_o 0, finish_o 0, counters and reference 0.
REQ-024 Reset mid-RUN, in DONE or in FAIL SHALL discard all history; monitoring restarts per REQ-013.

Configuration
REQ-025 Macro TB_CYCLE_MON_DPI_EN defined: on every entry to FAIL, SHALL call tb_pkg::tb_error once with file, line and a message naming the error code and fail cycle.
REQ-026 Macro TB_CYCLE_MON_DPI_EN undefined: SHALL contain no DPI calls (emulation/synthesis safe); reporting via outputs only, cycle behaviour identical.

Verification
REQ-027 Contiguous counter 100..199, activity_i every 5 cycles, done_i at 150 -> finish_o 1 one cycle later, err_o 0 throughout.
REQ-028 Counter 0xFFFFFFFD..0x00000003 -> no error across the wrap.
REQ-029 Counter skips 41 -> 43 -> err_o 1, err_code_o 1, fail_cycle_o 43 next cycle; further activity/done ignored.
REQ-030 WATCHDOG_CYCLES=4, activity_i low from RUN entry -> err_code_o 2 after the 4th idle cycle; activity_i on cycle 3 -> no error.
REQ-031 WATCHDOG_CYCLES=4, MAX_CYCLES=4, no activity, done_i on the same cycle -> err_code_o 2 (priority), finish_o 0.
REQ-032 arst pulsed one cycle while in FAIL -> all outputs 0 next cycle, new reference captured, clean run passes.
